// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns / bypass engine for a full 128-bit state.
// NCOL columns are transformed in place per RUN cycle; the result is held until out_ready.
module mix_columns_engine #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (!(NCOL == 1 || NCOL == 2 || NCOL == 4)) begin : g_bad_ncol
      $error("mix_columns_engine: NCOL must be 1, 2 or 4");
    end
  endgenerate

  localparam int         STEPS = 4 / NCOL;
  localparam logic [1:0] LAST  = 2'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t       state, state_d;
  logic [1:0]   cnt, cnt_d;
  logic [1:0]   mode, mode_d;
  logic [127:0] data, data_d;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples of each byte come from an xtime chain: x2, x4, x8.
  function automatic logic [31:0] mix(input logic [31:0] col, input logic [1:0] m);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] b  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      case (m)
        2'b00:   b[i] = x2[i] ^ (x2[(i+1)&3] ^ a[(i+1)&3]) ^ a[(i+2)&3] ^ a[(i+3)&3];
        2'b01:   b[i] = (x8[i] ^ x4[i] ^ x2[i])
                      ^ (x8[(i+1)&3] ^ x2[(i+1)&3] ^ a[(i+1)&3])
                      ^ (x8[(i+2)&3] ^ x4[(i+2)&3] ^ a[(i+2)&3])
                      ^ (x8[(i+3)&3] ^ a[(i+3)&3]);
        default: b[i] = a[i];
      endcase
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      mode  <= 2'd0;
      data  <= 128'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      mode  <= mode_d;
      data  <= data_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode;
    data_d  = data;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Slot j of this cycle handles column cnt*NCOL+j.
        for (int j = 0; j < NCOL; j++) begin
          data_d[127 - 32*(int'(cnt)*NCOL + j) -: 32] =
            mix(data[127 - 32*(int'(cnt)*NCOL + j) -: 32], mode);
        end
        cnt_d = cnt + 2'd1;
        if (cnt == LAST) begin
          cnt_d   = 2'd0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign out_data  = data;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed and round-trip bench for mix_columns_engine with NCOL=1, 2 and 4 instances side by side.
// Instance k: 0 -> NCOL=1, 1 -> NCOL=2, 2 -> NCOL=4.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic [1:0]   in_mode   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_columns_engine #(.NCOL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  mix_columns_engine #(.NCOL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_mode(in_mode[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  mix_columns_engine #(.NCOL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_mode(in_mode[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  // Reference model: generic shift-and-add GF(2^8) multiply over the circulant matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [127:0] r = 128'd0;
    logic [31:0]  w;
    logic [7:0]   acc;
    if (inv) begin coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09; end
    else     begin coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01; end
    for (int c = 0; c < 4; c++) begin
      w = s[127-32*c -: 32];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-i+4)%4], w[31-8*j -: 8]);
        r[127-32*c-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic int lat_exp(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [127:0] d, input logic [1:0] m,
                               output logic [127:0] res, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready[k] && n < 50) begin @(negedge clk); n++; end
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_mode[k]  = m;
    @(negedge clk);
    in_valid[k] = 1'b0;
    n = 0;
    while (!out_valid[k] && n < 50) begin @(negedge clk); n++; end
    lat = n;
    res = out_data[k];
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] res, orig, r1, r2, held;
    int lat, seen;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; in_mode[k] = 2'b00; out_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset state");
    for (int k = 0; k < 3; k++) begin
      checkOutput("rst_out_valid", 128'(out_valid[k]), 128'd0);
      checkOutput("rst_out_data", out_data[k], 128'd0);
      checkOutput("rst_busy", 128'(busy[k]), 128'd0);
      checkOutput("rst_in_ready", 128'(in_ready[k]), 128'd1);
    end

    $display("[TB] forward, NCOL=4");
    applyStimulus(2, {4{32'hdb135345}}, 2'b00, res, lat);
    checkOutput("t1_data", res, {4{32'h8e4da1bc}});
    checkOutput("t1_latency", 128'(lat), 128'd1);
    applyStimulus(2, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 2'b00, res, lat);
    checkOutput("t1_mixed", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

    $display("[TB] inverse, NCOL=1 and forward, NCOL=2");
    applyStimulus(0, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 2'b01, res, lat);
    checkOutput("t2_inv_data", res, 128'hdb135345_f20a225c_01010101_2d26314c);
    checkOutput("t2_latency", 128'(lat), 128'd4);
    applyStimulus(1, 128'h2d26314c_d4d4d4d5_c6c6c6c6_db135345, 2'b00, res, lat);
    checkOutput("t2_fwd_ncol2", res, 128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_8e4da1bc);
    checkOutput("t2_latency_ncol2", 128'(lat), 128'd2);

    $display("[TB] bypass");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k, 128'h00112233_44556677_8899aabb_ccddeeff, (k == 1) ? 2'b11 : 2'b10, res, lat);
      checkOutput("t3_bypass", res, 128'h00112233_44556677_8899aabb_ccddeeff);
      checkOutput("t3_latency", 128'(lat), 128'(lat_exp(k)));
    end

    $display("[TB] backpressure, NCOL=4");
    @(negedge clk);
    in_valid[2] = 1'b1; in_data[2] = {4{32'hdb135345}}; in_mode[2] = 2'b00;
    @(negedge clk);
    in_data[2] = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8; in_mode[2] = 2'b01;
    @(negedge clk);
    checkOutput("t4_out_valid", 128'(out_valid[2]), 128'd1);
    held = {4{32'h8e4da1bc}};
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_stable", out_data[2], held);
      checkOutput("t4_in_ready_low", 128'(in_ready[2]), 128'd0);
      @(negedge clk);
    end
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;
    checkOutput("t4_idle_out_valid", 128'(out_valid[2]), 128'd0);
    checkOutput("t4_idle_in_ready", 128'(in_ready[2]), 128'd1);
    @(negedge clk);
    in_valid[2] = 1'b0;
    checkOutput("t4_reaccept_busy", 128'(busy[2]), 128'd1);
    lat = 0;
    while (!out_valid[2] && lat < 50) begin @(negedge clk); lat++; end
    checkOutput("t4_second_data", out_data[2], 128'hdb135345_f20a225c_01010101_2d26314c);
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;

    $display("[TB] reset mid-operation, NCOL=1");
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = {4{32'hdb135345}}; in_mode[0] = 2'b00;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("t5_busy", 128'(busy[0]), 128'd0);
    checkOutput("t5_out_valid", 128'(out_valid[0]), 128'd0);
    checkOutput("t5_out_data", out_data[0], 128'd0);
    checkOutput("t5_in_ready", 128'(in_ready[0]), 128'd1);
    seen = 0;
    repeat (8) begin @(negedge clk); if (out_valid[0]) seen++; end
    checkOutput("t5_no_stale", 128'(seen), 128'd0);

    $display("[TB] random round trip");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        orig = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(k, orig, 2'b00, r1, lat);
        checkOutput("t6_fwd", r1, ref_mix(orig, 1'b0));
        applyStimulus(k, r1, 2'b01, r2, lat);
        checkOutput("t6_inv", r2, orig);
      end
      checkOutput("t6_latency", 128'(lat), 128'(lat_exp(k)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
